// File: rtl/router_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : router_fifo_if
// Brief    : Write/read handshake bundle between router, client and router_fifo
// Revision : 1.0 - initial release
// ============================================================================
interface router_fifo_if #(
  parameter int DW   = 8,
  parameter int LENW = 6
);
  logic          write_enb;
  logic          read_enb;
  logic          lfd_state;
  logic [DW-1:0] data_in;
  logic          full;
  logic          empty;
  logic [DW-1:0] data_out;
  logic [LENW:0] pkt_count;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  full, empty, data_out, pkt_count
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output full, empty, data_out, pkt_count
  );
endinterface
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
// Module   : router_fifo
// Brief    : Per-destination packet buffer with header tagging and read-side
//            remaining-byte counter.
// Revision : 1.0 - initial release
// ============================================================================
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int LENW  = 6
) (
  input  wire logic     clk,
  input  wire logic     resetn,
  input  wire logic     soft_reset,
  router_fifo_if.slave  bus
);

  localparam int c_WW = DW + 1;

  logic [c_WW-1:0] r_mem [DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic [DW-1:0]   r_data_out;
  logic [LENW:0]   r_pkt_count;

  logic            w_full;
  logic            w_empty;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic [c_WW-1:0] w_rd_word;
  logic [LENW:0]   w_hdr_len;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_wr_acc = bus.write_enb && !w_full;
  assign w_rd_acc = bus.read_enb && !w_empty;

  assign w_rd_word = r_mem[r_rptr[AW-1:0]];
  // Header length field plus one for the trailing parity byte.
  assign w_hdr_len = {1'b0, w_rd_word[LENW+1:2]} + {{LENW{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (!soft_reset && w_wr_acc) begin
      r_mem[r_wptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || soft_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || soft_reset) begin
      r_data_out  <= '0;
      r_pkt_count <= '0;
    end else if (w_rd_acc) begin
      r_data_out <= w_rd_word[DW-1:0];
      if (w_rd_word[DW]) begin
        r_pkt_count <= w_hdr_len;
      end else if (r_pkt_count != '0) begin
        r_pkt_count <= r_pkt_count - 1'b1;
      end
    end else if (r_pkt_count == '0) begin
      // Outside a packet the client sees a quiet bus.
      r_data_out <= '0;
    end
  end

  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.data_out  = r_data_out;
  assign bus.pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_router_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_fifo
// Brief    : Directed self-checking bench for router_fifo
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_fifo;

  logic clk = 1'b0;
  logic resetn;
  logic soft_reset;
  int   n_total = 0;
  int   n_pass  = 0;

  router_fifo_if #(.DW(8), .LENW(6)) bus ();

  router_fifo #(.DEPTH(16), .DW(8), .AW(4), .LENW(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = 8'h00;
  endtask

  task automatic write_byte(input logic hdr, input logic [7:0] d);
    bus.write_enb = 1'b1;
    bus.lfd_state = hdr;
    bus.data_in   = d;
    tick();
    idle_inputs();
  endtask

  task automatic read_check(input string tag, input logic [7:0] exp_d, input logic [6:0] exp_cnt);
    bus.read_enb = 1'b1;
    tick();
    bus.read_enb = 1'b0;
    check({tag, "_data"}, {24'h0, bus.data_out}, {24'h0, exp_d});
    check({tag, "_cnt"},  {25'h0, bus.pkt_count}, {25'h0, exp_cnt});
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  logic [7:0] seq [22];

  initial begin
    resetn     = 1'b0;
    soft_reset = 1'b0;
    idle_inputs();
    tick();
    resetn = 1'b1;

    // Random traffic, then a two-cycle reset.
    for (int i = 0; i < 8; i++) begin
      bus.write_enb = 1'($urandom);
      bus.read_enb  = 1'($urandom);
      bus.lfd_state = 1'($urandom);
      bus.data_in   = 8'($urandom);
      tick();
    end
    idle_inputs();
    pulse_reset();
    check("rst_empty", {31'h0, bus.empty}, 32'd1);
    check("rst_full",  {31'h0, bus.full},  32'd0);
    check("rst_data",  {24'h0, bus.data_out}, 32'h0);
    check("rst_cnt",   {25'h0, bus.pkt_count}, 32'h0);

    // Single packet, header length 3.
    write_byte(1'b1, 8'h0D);
    write_byte(1'b0, 8'h11);
    write_byte(1'b0, 8'h22);
    write_byte(1'b0, 8'h33);
    write_byte(1'b0, 8'h0F);
    check("pkt_not_empty", {31'h0, bus.empty}, 32'd0);
    read_check("pkt_hdr", 8'h0D, 7'd4);
    read_check("pkt_b1",  8'h11, 7'd3);
    read_check("pkt_b2",  8'h22, 7'd2);
    read_check("pkt_b3",  8'h33, 7'd1);
    read_check("pkt_par", 8'h0F, 7'd0);
    tick();
    check("pkt_idle_data", {24'h0, bus.data_out}, 32'h0);
    check("pkt_idle_empty", {31'h0, bus.empty}, 32'd1);

    // Fill and overflow (pointers start at 5, so this also wraps).
    for (int i = 0; i < 17; i++) begin
      write_byte(1'b0, 8'h40 + 8'(i));
      if (i == 14) check("fill15_full", {31'h0, bus.full}, 32'd0);
      if (i == 15) check("fill16_full", {31'h0, bus.full}, 32'd1);
    end
    check("fill17_full", {31'h0, bus.full}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      read_check("fill_rd", 8'h40 + 8'(i), 7'd0);
    end
    check("fill_drained", {31'h0, bus.empty}, 32'd1);

    // Wrap with concurrent read/write streaming.
    pulse_reset();
    for (int i = 0; i < 12; i++) write_byte(1'b0, 8'(i));
    for (int i = 0; i < 12; i++) read_check("pre_rd", 8'(i), 7'd0);
    write_byte(1'b0, 8'hA0);
    write_byte(1'b0, 8'hA1);
    seq[0] = 8'hA0;
    seq[1] = 8'hA1;
    for (int i = 0; i < 20; i++) seq[i+2] = 8'hB0 + 8'(i);
    for (int i = 0; i < 20; i++) begin
      bus.write_enb = 1'b1;
      bus.read_enb  = 1'b1;
      bus.data_in   = 8'hB0 + 8'(i);
      tick();
      check("stream_data", {24'h0, bus.data_out}, {24'h0, seq[i]});
      check("stream_full", {31'h0, bus.full}, 32'd0);
      check("stream_empty", {31'h0, bus.empty}, 32'd0);
    end
    idle_inputs();
    read_check("stream_tail0", seq[20], 7'd0);
    read_check("stream_tail1", seq[21], 7'd0);
    check("stream_drained", {31'h0, bus.empty}, 32'd1);

    // Collision while full: read taken, write dropped.
    for (int i = 0; i < 16; i++) write_byte(1'b0, 8'h60 + 8'(i));
    check("col_full", {31'h0, bus.full}, 32'd1);
    bus.write_enb = 1'b1;
    bus.read_enb  = 1'b1;
    bus.data_in   = 8'hEE;
    tick();
    idle_inputs();
    check("colf_data", {24'h0, bus.data_out}, 32'h60);
    check("colf_full", {31'h0, bus.full}, 32'd0);
    for (int i = 1; i < 16; i++) read_check("colf_rd", 8'h60 + 8'(i), 7'd0);
    check("colf_empty", {31'h0, bus.empty}, 32'd1);
    tick();
    check("colf_idle", {24'h0, bus.data_out}, 32'h0);

    // Collision while empty: write taken, read refused.
    bus.write_enb = 1'b1;
    bus.read_enb  = 1'b1;
    bus.data_in   = 8'h77;
    tick();
    idle_inputs();
    check("cole_data", {24'h0, bus.data_out}, 32'h0);
    check("cole_empty", {31'h0, bus.empty}, 32'd0);
    read_check("cole_rd", 8'h77, 7'd0);

    // Soft reset mid-packet, with a write in the same cycle discarded.
    write_byte(1'b1, 8'h29);
    for (int i = 1; i <= 4; i++) write_byte(1'b0, 8'(i));
    read_check("sr_hdr", 8'h29, 7'd11);
    read_check("sr_b1",  8'h01, 7'd10);
    soft_reset    = 1'b1;
    bus.write_enb = 1'b1;
    bus.data_in   = 8'h99;
    tick();
    soft_reset = 1'b0;
    idle_inputs();
    check("sr_empty", {31'h0, bus.empty}, 32'd1);
    check("sr_cnt",   {25'h0, bus.pkt_count}, 32'h0);
    check("sr_data",  {24'h0, bus.data_out}, 32'h0);
    write_byte(1'b1, 8'h05);
    write_byte(1'b0, 8'hAB);
    write_byte(1'b0, 8'hCC);
    read_check("sr2_hdr", 8'h05, 7'd2);
    read_check("sr2_b1",  8'hAB, 7'd1);
    read_check("sr2_par", 8'hCC, 7'd0);

    // Zero-length header: parity byte only.
    write_byte(1'b1, 8'h02);
    write_byte(1'b0, 8'h55);
    read_check("z_hdr", 8'h02, 7'd1);
    tick();
    check("z_hold", {24'h0, bus.data_out}, 32'h02);
    read_check("z_par", 8'h55, 7'd0);
    tick();
    check("z_idle", {24'h0, bus.data_out}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
